// File: rtl/rally_referee.sv
// rtl/rally_referee.sv - rally rules: touch counting, over-touch fault, side-out scoring
module rally_referee #(
    parameter int MAX_TOUCH  = 3,
    parameter int WIN_SCORE  = 15,
    parameter int NET_X      = 512,
    parameter int BALL_SIZE  = 64,
    parameter int HOLD_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        pl1_col,
    input  logic        pl2_col,
    input  logic        gnd_col,
    input  logic [11:0] ball_posx,
    output logic        ovr_touch,
    output logic [3:0]  pl1_score,
    output logic [3:0]  pl2_score,
    output logic        serve_side,
    output logic        point_pulse,
    output logic        rally_winner,
    output logic        game_over,
    output logic        winner
);

    typedef enum logic [1:0] {S_SERVE, S_RALLY, S_POINT, S_GAME_OVER} state_t;

    state_t      state_q, state_d;
    logic [2:0]  touch_cnt_q, touch_cnt_d;
    logic        touch_owner_q, touch_owner_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  col_prev_q, col_prev_d;
    logic        ovr_touch_q, ovr_touch_d;
    logic [3:0]  pl1_score_q, pl1_score_d;
    logic [3:0]  pl2_score_q, pl2_score_d;
    logic        serve_side_q, serve_side_d;
    logic        point_pulse_q, point_pulse_d;
    logic        rally_winner_q, rally_winner_d;
    logic        game_over_q, game_over_d;
    logic        winner_q, winner_d;

    logic [12:0] centre;
    logic        centre_right;
    logic        rise1, rise2, touch_any, toucher;

    // Centre is widened to 13 bits so a ball near the right edge never wraps left.
    assign centre       = {1'b0, ball_posx} + 13'(BALL_SIZE / 2);
    assign centre_right = (centre >= 13'(NET_X));
    assign rise1        = pl1_col & ~col_prev_q[0];
    assign rise2        = pl2_col & ~col_prev_q[1];
    assign touch_any    = rise1 | rise2;
    assign toucher      = (rise1 & rise2) ? centre_right : rise2;

    logic       resolve;
    logic       rw;
    logic [2:0] next_cnt;
    logic [3:0] new_score;

    always_comb begin
        state_d        = state_q;
        touch_cnt_d    = touch_cnt_q;
        touch_owner_d  = touch_owner_q;
        hold_cnt_d     = hold_cnt_q;
        col_prev_d     = col_prev_q;
        ovr_touch_d    = ovr_touch_q;
        pl1_score_d    = pl1_score_q;
        pl2_score_d    = pl2_score_q;
        serve_side_d   = serve_side_q;
        point_pulse_d  = 1'b0;
        rally_winner_d = rally_winner_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        resolve        = 1'b0;
        rw             = 1'b0;
        next_cnt       = touch_cnt_q + 3'd1;
        new_score      = 4'd0;

        if (tick) begin
            col_prev_d = {pl2_col, pl1_col};
            case (state_q)
                S_SERVE: begin
                    if (touch_any) begin
                        state_d       = S_RALLY;
                        touch_owner_d = toucher;
                        touch_cnt_d   = 3'd1;
                    end
                end
                S_RALLY: begin
                    // Ground contact outranks any touch on the same tick.
                    if (gnd_col) begin
                        resolve = 1'b1;
                        rw      = ~centre_right;
                    end else if (touch_any) begin
                        if (toucher == touch_owner_q) begin
                            touch_cnt_d = next_cnt;
                            if (next_cnt == 3'(MAX_TOUCH + 1)) begin
                                ovr_touch_d = 1'b1;
                                resolve     = 1'b1;
                                rw          = ~touch_owner_q;
                            end
                        end else begin
                            touch_owner_d = toucher;
                            touch_cnt_d   = 3'd1;
                        end
                    end
                end
                S_POINT: begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    if (hold_cnt_q == 8'(HOLD_TICKS - 1)) begin
                        state_d     = S_SERVE;
                        ovr_touch_d = 1'b0;
                        touch_cnt_d = 3'd0;
                        hold_cnt_d  = 8'd0;
                    end
                end
                default: ;
            endcase

            if (resolve) begin
                rally_winner_d = rw;
                point_pulse_d  = 1'b1;
                state_d        = S_POINT;
                hold_cnt_d     = 8'd0;
                // Side-out: only the serving side can score; otherwise serve changes hands.
                if (rw == serve_side_q) begin
                    new_score = rw ? pl2_score_q : pl1_score_q;
                    if (new_score != 4'(WIN_SCORE))
                        new_score = new_score + 4'd1;
                    if (rw)
                        pl2_score_d = new_score;
                    else
                        pl1_score_d = new_score;
                    if (new_score == 4'(WIN_SCORE)) begin
                        state_d     = S_GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = rw;
                    end
                end else begin
                    serve_side_d = rw;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_SERVE;
            touch_cnt_q    <= 3'd0;
            touch_owner_q  <= 1'b0;
            hold_cnt_q     <= 8'd0;
            col_prev_q     <= 2'b00;
            ovr_touch_q    <= 1'b0;
            pl1_score_q    <= 4'd0;
            pl2_score_q    <= 4'd0;
            serve_side_q   <= 1'b0;
            point_pulse_q  <= 1'b0;
            rally_winner_q <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            touch_cnt_q    <= touch_cnt_d;
            touch_owner_q  <= touch_owner_d;
            hold_cnt_q     <= hold_cnt_d;
            col_prev_q     <= col_prev_d;
            ovr_touch_q    <= ovr_touch_d;
            pl1_score_q    <= pl1_score_d;
            pl2_score_q    <= pl2_score_d;
            serve_side_q   <= serve_side_d;
            point_pulse_q  <= point_pulse_d;
            rally_winner_q <= rally_winner_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
        end
    end

    assign ovr_touch    = ovr_touch_q;
    assign pl1_score    = pl1_score_q;
    assign pl2_score    = pl2_score_q;
    assign serve_side   = serve_side_q;
    assign point_pulse  = point_pulse_q;
    assign rally_winner = rally_winner_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: doc/rally_referee.md
Name: rally_referee

Overview:
- Game-rules stage directly downstream of the ball position controller.
- Consumes the ground-collision flag, the player-collision flags and the ball X position, all sampled on the 100 Hz game tick.
- Counts consecutive touches per player and drives the over-touch fault (`ovr_touch`) back into the ball controller.
- Keeps side-out scores, serve side and match-over status for the scoreboard and renderer.

Parameters:
- MAX_TOUCH, 3, legal consecutive touches by one player; touch MAX_TOUCH+1 is a fault.
- WIN_SCORE, 15, score that ends the match.
- NET_X, 512, court split X coordinate in pixels.
- BALL_SIZE, 64, ball sprite width; ball centre = ball_posx + BALL_SIZE/2.
- HOLD_TICKS, 250, ticks held in POINT after a rally ends; matches the ball controller wait time.

Ports:
- clk  in  1  65 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide 100 Hz strobe; all game logic advances only when tick=1.
- pl1_col  in  1  player 1 / ball collision (level).
- pl2_col  in  1  player 2 / ball collision (level).
- gnd_col  in  1  ball on ground (level).
- ball_posx  in  12  ball left edge X, pixels.
- ovr_touch  out  1  over-touch fault flag.
- pl1_score  out  4  player 1 score.
- pl2_score  out  4  player 2 score.
- serve_side  out  1  0 = PL1 serves, 1 = PL2 serves.
- point_pulse  out  1  one-clk pulse when a rally is resolved.
- rally_winner  out  1  winner of the last resolved rally (0 = PL1, 1 = PL2).
- game_over  out  1  match finished.
- winner  out  1  match winner; valid while game_over=1.

Behaviour:
- Reset: all outputs 0; state SERVE; touch_cnt=0; touch_owner=0; hold_cnt=0; col_prev=0.
- Reset has priority on any clk edge, including mid-HOLD and in GAME_OVER.
- Registers change only on clk edges with tick=1. Exception: point_pulse, which falls on the next clk.
- Touch event: rising edge of plX_col versus col_prev, where col_prev is sampled each tick. A held collision counts once.
- Both players rise on the same tick: one touch, credited to the side holding the ball centre (centre < NET_X → PL1, else PL2).
- Ball side for landing: centre computed at 13-bit width, no wrap. Centre < NET_X → left (PL1 court); otherwise right.

State SERVE:
- Counters are 0; ovr_touch=0.
- First touch event → RALLY, with touch_owner = toucher and touch_cnt = 1.
- gnd_col is ignored in SERVE.

State RALLY, priority order per tick:
1. gnd_col=1: rally loser is the owner of the landing court; winner is the other player. Go to resolve.
2. Touch by touch_owner: touch_cnt+1. If the result equals MAX_TOUCH+1, set ovr_touch=1, winner is the opponent, go to resolve.
3. Touch by the opponent: touch_owner = opponent; touch_cnt = 1.

Resolve (same tick):
- rally_winner = winner; point_pulse=1 for one clk.
- Side-out scoring: if winner == serve_side, that player's score +1. Otherwise serve_side = winner and no score change.
- If the new score == WIN_SCORE → GAME_OVER with winner set.
- Otherwise → POINT with hold_cnt=0.

State POINT:
- hold_cnt increments each tick; touches and gnd_col are ignored; ovr_touch is held.
- When hold_cnt == HOLD_TICKS-1 → SERVE; ovr_touch cleared; touch_cnt=0.

State GAME_OVER:
- All inputs ignored; outputs frozen; only rst exits.

Widths and limits:
- Scores saturate at WIN_SCORE.
- touch_cnt is 3 bits; hold_cnt is 8 bits.

Test Plan:
- Serve and win: rst; serve_side=0; pl1_col rises on a tick; later gnd_col=1 with ball_posx=700 → point_pulse one clk, rally_winner=0, pl1_score=1, serve_side=0, POINT held 250 ticks then SERVE.
- Side-out: PL1 serving; touch by PL1; gnd_col with ball_posx=100 → rally_winner=1, pl2_score=0, pl1_score unchanged, serve_side=1.
- Over-touch: four separate pl2_col rising edges, no pl1 touches → ovr_touch=1 on the 4th tick, rally_winner=0, ovr_touch held exactly 250 ticks, then cleared.
- Held contact and alternation:
  - pl1_col held high for 10 ticks counts as 1 touch.
  - Sequence pl1, pl1, pl1, pl2, pl1 edges → ovr_touch stays 0.
  - Edges with tick=0 are not counted.
- Match end and priority:
  - pl1_score=14 and PL1 serving; gnd_col on the right at ball_posx=600 together with a 4th PL1 touch on the same tick → ground wins, pl1_score=15, game_over=1, winner=0.
  - Later collisions leave all outputs frozen.
- Reset mid-operation: rst asserted during POINT with hold_cnt=100 → next clk all outputs 0 and state SERVE. Also assert rst in GAME_OVER → same result.
